// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter slice.
package sram_arb_pkg;

  localparam int unsigned SRAM_ADDR_WD_DEF = 9;
  localparam int unsigned SRAM_DATA_WD_DEF = 32;
  localparam int unsigned NUM_RQ           = 2;

  // Requester indices
  localparam int unsigned RQ_WB   = 0;
  localparam int unsigned RQ_FILL = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_RD    = 3'd2,
    ST_RWAIT = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM-pin bundle for the SRAM port arbiter.
interface sram_port_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WD = SRAM_ADDR_WD_DEF,
  parameter int unsigned DATA_WD = SRAM_DATA_WD_DEF
);
  localparam int unsigned MASK_WD = DATA_WD / 8;

  // Requester side
  logic [NUM_RQ-1:0]  rq_req_i;
  logic [NUM_RQ-1:0]  rq_we_i;
  logic [ADDR_WD-1:0] rq0_addr_i;
  logic [ADDR_WD-1:0] rq1_addr_i;
  logic [DATA_WD-1:0] rq0_wdata_i;
  logic [DATA_WD-1:0] rq1_wdata_i;
  logic [MASK_WD-1:0] rq0_mask_i;
  logic [MASK_WD-1:0] rq1_mask_i;
  logic [NUM_RQ-1:0]  rq_ack_o;
  logic [DATA_WD-1:0] rq_rdata_o;
  logic               busy_o;

  // SRAM macro side
  logic               sram_csb_a;
  logic [ADDR_WD-1:0] sram_addr_a;
  logic [DATA_WD-1:0] sram_dout_a;
  logic               sram_csb_b;
  logic               sram_web_b;
  logic [MASK_WD-1:0] sram_mask_b;
  logic [ADDR_WD-1:0] sram_addr_b;
  logic [DATA_WD-1:0] sram_din_b;

  // Arbiter view
  modport slave (
    input  rq_req_i, rq_we_i, rq0_addr_i, rq1_addr_i,
    input  rq0_wdata_i, rq1_wdata_i, rq0_mask_i, rq1_mask_i,
    output rq_ack_o, rq_rdata_o, busy_o,
    output sram_csb_a, sram_addr_a,
    input  sram_dout_a,
    output sram_csb_b, sram_web_b, sram_mask_b, sram_addr_b, sram_din_b
  );

  // Requesters plus SRAM macro view
  modport master (
    output rq_req_i, rq_we_i, rq0_addr_i, rq1_addr_i,
    output rq0_wdata_i, rq1_wdata_i, rq0_mask_i, rq1_mask_i,
    input  rq_ack_o, rq_rdata_o, busy_o,
    input  sram_csb_a, sram_addr_a,
    output sram_dout_a,
    input  sram_csb_b, sram_web_b, sram_mask_b, sram_addr_b, sram_din_b
  );

endinterface

// File: rtl/sram_port_arbiter_rr.sv
// Two-way round-robin pick with a registered priority pointer.
module rr_arbiter2
  import sram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_RQ-1:0] req,
  input  logic              gnt_en,
  output logic              gnt_valid_c,
  output logic              gnt_idx_c
);

  // ptr holds the index that wins a tie
  logic ptr;

  // Tie goes to the pointer; a lone requester always wins
  always_comb begin
    gnt_valid_c = |req;
    gnt_idx_c   = 1'(RQ_WB);
    if (req[RQ_WB] && req[RQ_FILL]) begin
      gnt_idx_c = ptr;
    end else begin
      gnt_idx_c = req[RQ_FILL];
    end
  end

  // Move the pointer past the winner on every accepted grant
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'(RQ_WB);
    end else if (gnt_en && gnt_valid_c) begin
      ptr <= ~gnt_idx_c;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Serialises two requesters onto a read-port-A / write-port-B SRAM macro.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned READ_WAIT = 1
) (
  input  logic              wb_clk_i,
  input  logic              rst_i,
  sram_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_WD = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  arb_state_e                   state;
  logic                         gnt;
  logic [CNT_WD-1:0]            cnt;
  logic                         gnt_valid_c;
  logic                         gnt_idx_c;
  logic                         sel_we_c;
  logic [$bits(bus.rq0_addr_i)-1:0]  sel_addr_c;
  logic [$bits(bus.rq0_wdata_i)-1:0] sel_wdata_c;
  logic [$bits(bus.rq0_mask_i)-1:0]  sel_mask_c;

  rr_arbiter2 u_rr (
    .clk         (wb_clk_i),
    .rst         (rst_i),
    .req         (bus.rq_req_i),
    .gnt_en      (state == ST_IDLE),
    .gnt_valid_c (gnt_valid_c),
    .gnt_idx_c   (gnt_idx_c)
  );

  // Route the winning requester's command fields
  always_comb begin
    sel_we_c    = bus.rq_we_i[gnt_idx_c];
    sel_addr_c  = gnt_idx_c ? bus.rq1_addr_i  : bus.rq0_addr_i;
    sel_wdata_c = gnt_idx_c ? bus.rq1_wdata_i : bus.rq0_wdata_i;
    sel_mask_c  = gnt_idx_c ? bus.rq1_mask_i  : bus.rq0_mask_i;
  end

  // Access FSM; SRAM pins, ack, rdata and busy are all registered here
  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      state           <= ST_IDLE;
      gnt             <= 1'(RQ_WB);
      cnt             <= '0;
      bus.busy_o      <= 1'b0;
      bus.rq_ack_o    <= '0;
      bus.rq_rdata_o  <= '0;
      bus.sram_csb_a  <= 1'b1;
      bus.sram_addr_a <= '0;
      bus.sram_csb_b  <= 1'b1;
      bus.sram_web_b  <= 1'b1;
      bus.sram_mask_b <= '0;
      bus.sram_addr_b <= '0;
      bus.sram_din_b  <= '0;
    end else begin
      bus.rq_ack_o <= '0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid_c) begin
            gnt        <= gnt_idx_c;
            bus.busy_o <= 1'b1;
            if (sel_we_c) begin
              state           <= ST_WR;
              bus.sram_csb_b  <= 1'b0;
              bus.sram_web_b  <= 1'b0;
              bus.sram_addr_b <= sel_addr_c;
              bus.sram_din_b  <= sel_wdata_c;
              bus.sram_mask_b <= sel_mask_c;
            end else begin
              state           <= ST_RD;
              bus.sram_csb_a  <= 1'b0;
              bus.sram_addr_a <= sel_addr_c;
            end
          end
        end
        ST_WR: begin
          bus.sram_csb_b <= 1'b1;
          bus.sram_web_b <= 1'b1;
          bus.rq_ack_o   <= gnt ? 2'b10 : 2'b01;
          state          <= ST_DONE;
        end
        ST_RD: begin
          bus.sram_csb_a <= 1'b1;
          cnt            <= CNT_WD'(READ_WAIT - 1);
          state          <= ST_RWAIT;
        end
        ST_RWAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_WD'(1);
          end else begin
            bus.rq_rdata_o <= bus.sram_dout_a;
            bus.rq_ack_o   <= gnt ? 2'b10 : 2'b01;
            state          <= ST_DONE;
          end
        end
        ST_DONE: begin
          bus.busy_o <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          bus.busy_o <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural dual-port SRAM.
module tb_sram_port_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [31:0] mem  [512];
  logic [31:0] mem3 [512];

  sram_port_arbiter_if bus  ();
  sram_port_arbiter_if bus3 ();

  sram_port_arbiter #(.READ_WAIT(1)) dut (
    .wb_clk_i (clk),
    .rst_i    (rst),
    .bus      (bus)
  );

  sram_port_arbiter #(.READ_WAIT(3)) dut3 (
    .wb_clk_i (clk),
    .rst_i    (rst),
    .bus      (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model for the READ_WAIT=1 instance
  always @(posedge clk) begin
    if (!bus.sram_csb_b && !bus.sram_web_b) begin
      for (int b = 0; b < 4; b++)
        if (bus.sram_mask_b[b]) mem[bus.sram_addr_b][8*b +: 8] <= bus.sram_din_b[8*b +: 8];
    end
    if (!bus.sram_csb_a) bus.sram_dout_a <= mem[bus.sram_addr_a];
  end

  // SRAM model for the READ_WAIT=3 instance
  always @(posedge clk) begin
    if (!bus3.sram_csb_b && !bus3.sram_web_b) begin
      for (int b = 0; b < 4; b++)
        if (bus3.sram_mask_b[b]) mem3[bus3.sram_addr_b][8*b +: 8] <= bus3.sram_din_b[8*b +: 8];
    end
    if (!bus3.sram_csb_a) bus3.sram_dout_a <= mem3[bus3.sram_addr_a];
  end

  task automatic clear_inputs();
    bus.rq_req_i = '0;  bus.rq_we_i = '0;
    bus.rq0_addr_i = '0; bus.rq1_addr_i = '0;
    bus.rq0_wdata_i = '0; bus.rq1_wdata_i = '0;
    bus.rq0_mask_i = '0; bus.rq1_mask_i = '0;
    bus3.rq_req_i = '0; bus3.rq_we_i = '0;
    bus3.rq0_addr_i = '0; bus3.rq1_addr_i = '0;
    bus3.rq0_wdata_i = '0; bus3.rq1_wdata_i = '0;
    bus3.rq0_mask_i = '0; bus3.rq1_mask_i = '0;
  endtask

  // Requester 0 write on either instance, waiting (bounded) for its ack
  task automatic wr0(input bit use3, input logic [8:0] a, input logic [31:0] d,
                     input logic [3:0] m);
    bit got = 0;
    if (use3) begin
      bus3.rq0_addr_i = a; bus3.rq0_wdata_i = d; bus3.rq0_mask_i = m;
      bus3.rq_we_i[0] = 1'b1; bus3.rq_req_i[0] = 1'b1;
    end else begin
      bus.rq0_addr_i = a; bus.rq0_wdata_i = d; bus.rq0_mask_i = m;
      bus.rq_we_i[0] = 1'b1; bus.rq_req_i[0] = 1'b1;
    end
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = use3 ? bus3.rq_ack_o[0] : bus.rq_ack_o[0];
    end
    total++;
    if (!got) begin bad++; $display("FAIL wr0_ack addr=%h: no ack within 10 cycles", a); end
    bus.rq_req_i[0] = 1'b0; bus3.rq_req_i[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    total++;
    if ({bus.sram_csb_a, bus.sram_csb_b, bus.sram_web_b} !== 3'b111) begin
      bad++; $display("FAIL reset_selects got=%b want=111", {bus.sram_csb_a, bus.sram_csb_b, bus.sram_web_b});
    end
    total++;
    if ({bus.sram_addr_a, bus.sram_addr_b, bus.sram_mask_b} !== 22'd0) begin
      bad++; $display("FAIL reset_addr_mask got=%h want=0", {bus.sram_addr_a, bus.sram_addr_b, bus.sram_mask_b});
    end
    total++;
    if (bus.sram_din_b !== 32'd0 || bus.rq_rdata_o !== 32'd0) begin
      bad++; $display("FAIL reset_data din=%h rdata=%h want=0", bus.sram_din_b, bus.rq_rdata_o);
    end
    total++;
    if (bus.rq_ack_o !== 2'b00 || bus.busy_o !== 1'b0) begin
      bad++; $display("FAIL reset_ack_busy ack=%b busy=%b want=00/0", bus.rq_ack_o, bus.busy_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    bus.rq0_addr_i = 9'h005; bus.rq0_wdata_i = 32'hDEADBEEF; bus.rq0_mask_i = 4'hF;
    bus.rq_we_i[0] = 1'b1; bus.rq_req_i[0] = 1'b1;
    @(negedge clk); // cycle 1
    total++;
    if ({bus.sram_csb_b, bus.sram_web_b, bus.sram_csb_a} !== 3'b001) begin
      bad++; $display("FAIL wr_selects got=%b want=001", {bus.sram_csb_b, bus.sram_web_b, bus.sram_csb_a});
    end
    total++;
    if (bus.sram_addr_b !== 9'h005 || bus.sram_din_b !== 32'hDEADBEEF || bus.sram_mask_b !== 4'hF) begin
      bad++; $display("FAIL wr_bus addr=%h din=%h mask=%h want=005/deadbeef/f",
                      bus.sram_addr_b, bus.sram_din_b, bus.sram_mask_b);
    end
    total++;
    if (bus.busy_o !== 1'b1 || bus.rq_ack_o !== 2'b00) begin
      bad++; $display("FAIL wr_cycle1 busy=%b ack=%b want=1/00", bus.busy_o, bus.rq_ack_o);
    end
    @(negedge clk); // cycle 2
    total++;
    if (bus.rq_ack_o !== 2'b01 || bus.sram_csb_b !== 1'b1) begin
      bad++; $display("FAIL wr_ack ack=%b csb_b=%b want=01/1", bus.rq_ack_o, bus.sram_csb_b);
    end
    bus.rq_req_i[0] = 1'b0;
    @(negedge clk); // cycle 3
    total++;
    if (bus.rq_ack_o !== 2'b00 || bus.busy_o !== 1'b0) begin
      bad++; $display("FAIL wr_after ack=%b busy=%b want=00/0", bus.rq_ack_o, bus.busy_o);
    end
  endtask

  task automatic test_read();
    bus.rq1_addr_i = 9'h005; bus.rq_we_i[1] = 1'b0; bus.rq_req_i[1] = 1'b1;
    @(negedge clk); // cycle 1
    total++;
    if (bus.sram_csb_a !== 1'b0 || bus.sram_addr_a !== 9'h005 || bus.sram_csb_b !== 1'b1) begin
      bad++; $display("FAIL rd_issue csb_a=%b addr_a=%h csb_b=%b want=0/005/1",
                      bus.sram_csb_a, bus.sram_addr_a, bus.sram_csb_b);
    end
    @(negedge clk); // cycle 2
    total++;
    if (bus.rq_ack_o !== 2'b00 || bus.sram_csb_a !== 1'b1) begin
      bad++; $display("FAIL rd_wait ack=%b csb_a=%b want=00/1", bus.rq_ack_o, bus.sram_csb_a);
    end
    @(negedge clk); // cycle 3
    total++;
    if (bus.rq_ack_o !== 2'b10 || bus.rq_rdata_o !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rd_ack ack=%b rdata=%h want=10/deadbeef", bus.rq_ack_o, bus.rq_rdata_o);
    end
    bus.rq_req_i[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_byte_mask();
    wr0(1'b0, 9'h010, 32'hA5A5A5A5, 4'hF);
    bus.rq0_addr_i = 9'h010; bus.rq0_wdata_i = 32'h11223344; bus.rq0_mask_i = 4'b0010;
    bus.rq_we_i[0] = 1'b1; bus.rq_req_i[0] = 1'b1;
    @(negedge clk);
    total++;
    if (bus.sram_mask_b !== 4'b0010 || bus.sram_csb_b !== 1'b0) begin
      bad++; $display("FAIL mask_b got=%b csb_b=%b want=0010/0", bus.sram_mask_b, bus.sram_csb_b);
    end
    @(negedge clk);
    bus.rq_req_i[0] = 1'b0;
    @(negedge clk);
    bus.rq_we_i[0] = 1'b0; bus.rq_req_i[0] = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk); // cycle 3
    total++;
    if (bus.rq_ack_o !== 2'b01 || bus.rq_rdata_o !== 32'hA5A533A5) begin
      bad++; $display("FAIL mask_readback ack=%b rdata=%h want=01/a5a533a5", bus.rq_ack_o, bus.rq_rdata_o);
    end
    bus.rq_req_i[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [1:0]  order [4];
    logic [31:0] rd    [4];
    int n = 0;
    int clash = 0;
    wr0(1'b0, 9'h020, 32'h20202020, 4'hF);
    wr0(1'b0, 9'h021, 32'h21212121, 4'hF);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    bus.rq0_addr_i = 9'h020; bus.rq1_addr_i = 9'h021;
    bus.rq_we_i = 2'b00; bus.rq_req_i = 2'b11;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (!bus.sram_csb_a && !bus.sram_csb_b) clash++;
      if (bus.rq_ack_o != 2'b00) begin
        order[n] = bus.rq_ack_o; rd[n] = bus.rq_rdata_o; n++;
      end
    end
    bus.rq_req_i = 2'b00;
    total++;
    if (n != 4) begin bad++; $display("FAIL rr_count got=%0d acks want=4", n); end
    total++;
    if (clash != 0) begin bad++; $display("FAIL rr_port_clash got=%0d cycles want=0", clash); end
    for (int i = 0; i < n; i++) begin
      total++;
      if (order[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL rr_order[%0d] got=%b want=%b", i, order[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      total++;
      if (rd[i] !== ((i % 2 == 0) ? 32'h20202020 : 32'h21212121)) begin
        bad++; $display("FAIL rr_rdata[%0d] got=%h want=%h", i, rd[i],
                        (i % 2 == 0) ? 32'h20202020 : 32'h21212121);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.rq0_addr_i = 9'h005; bus.rq_we_i = 2'b00; bus.rq_req_i = 2'b01;
    @(negedge clk); @(negedge clk); // cycle 2: RWAIT
    rst = 1'b1; bus.rq_req_i = 2'b00;
    @(negedge clk);
    total++;
    if (bus.sram_csb_a !== 1'b1 || bus.busy_o !== 1'b0 || bus.rq_ack_o !== 2'b00) begin
      bad++; $display("FAIL rstmid_state csb_a=%b busy=%b ack=%b want=1/0/00",
                      bus.sram_csb_a, bus.busy_o, bus.rq_ack_o);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rq_ack_o !== 2'b00) begin bad++; $display("FAIL rstmid_no_ack got=%b want=00", bus.rq_ack_o); end
    // both request; requester 0 (a write) must win after reset
    bus.rq0_addr_i = 9'h030; bus.rq0_wdata_i = 32'h0BADF00D; bus.rq0_mask_i = 4'hF;
    bus.rq1_addr_i = 9'h005; bus.rq_we_i = 2'b01; bus.rq_req_i = 2'b11;
    @(negedge clk);
    total++;
    if (bus.sram_csb_b !== 1'b0 || bus.sram_addr_b !== 9'h030 || bus.sram_csb_a !== 1'b1) begin
      bad++; $display("FAIL rstmid_regrant csb_b=%b addr_b=%h csb_a=%b want=0/030/1",
                      bus.sram_csb_b, bus.sram_addr_b, bus.sram_csb_a);
    end
    @(negedge clk);
    total++;
    if (bus.rq_ack_o !== 2'b01) begin bad++; $display("FAIL rstmid_ack got=%b want=01", bus.rq_ack_o); end
    bus.rq_req_i = 2'b00;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_read_wait3();
    wr0(1'b1, 9'h007, 32'hCAFEF00D, 4'hF);
    bus3.rq1_addr_i = 9'h007; bus3.rq_we_i = 2'b00; bus3.rq_req_i = 2'b10;
    @(negedge clk); // cycle 1
    total++;
    if (bus3.sram_csb_a !== 1'b0 || bus3.sram_addr_a !== 9'h007) begin
      bad++; $display("FAIL rw3_issue csb_a=%b addr_a=%h want=0/007", bus3.sram_csb_a, bus3.sram_addr_a);
    end
    @(negedge clk); @(negedge clk); @(negedge clk); // cycle 4
    total++;
    if (bus3.rq_ack_o !== 2'b00 || bus3.busy_o !== 1'b1) begin
      bad++; $display("FAIL rw3_early ack=%b busy=%b want=00/1", bus3.rq_ack_o, bus3.busy_o);
    end
    @(negedge clk); // cycle 5
    total++;
    if (bus3.rq_ack_o !== 2'b10 || bus3.rq_rdata_o !== 32'hCAFEF00D) begin
      bad++; $display("FAIL rw3_ack ack=%b rdata=%h want=10/cafef00d", bus3.rq_ack_o, bus3.rq_rdata_o);
    end
    bus3.rq_req_i = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_inputs();
    bus.sram_dout_a  = '0;
    bus3.sram_dout_a = '0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_byte_mask();
    test_round_robin();
    test_reset_mid();
    test_read_wait3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
